// File: rtl/width_adapt_pkg.sv
// rtl/width_adapt_pkg.sv - shared types and helpers for narrow-to-wide width adaptation
package width_adapt_pkg;

  typedef enum logic {PK_FILL, PK_EMIT} pack_state_e;

  // Returns 0 when the widths do not divide evenly so the caller can reject it at elaboration.
  function automatic int lane_ratio(input int wide, input int narrow);
    if (narrow <= 0 || (wide % narrow) != 0) return 0;
    return wide / narrow;
  endfunction

endpackage

// File: rtl/idle_timeout_ctr.sv
// rtl/idle_timeout_ctr.sv - idle-cycle timer; expired marks the TIMEOUT-th consecutive enabled cycle
module idle_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [TW-1:0] timer;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      timer <= '0;
    end else if (en && timer != LAST) begin
      timer <= timer + 1'b1;
    end
  end

  // The cycle in which the timer already holds TIMEOUT-1 is the TIMEOUT-th idle cycle.
  assign expired = (TIMEOUT != 0) & en & (timer == LAST);

endmodule

// File: rtl/narrow_to_wide_packer.sv
// rtl/narrow_to_wide_packer.sv - packs narrow beats into wide words with flush and idle-timeout
import width_adapt_pkg::*;

module narrow_to_wide_packer #(
  parameter int NARROW_W = 8,
  parameter int WIDE_W   = 16,
  parameter int TIMEOUT  = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [NARROW_W-1:0]                       in_data,
  input  logic                                      flush,
  output logic                                      out_valid,
  input  logic                                      out_ready,
  output logic [WIDE_W-1:0]                         out_data,
  output logic [$clog2(WIDE_W/NARROW_W+1)-1:0]      out_beats,
  output logic                                      out_padded,
  output logic                                      busy
);

  localparam int RATIO = lane_ratio(WIDE_W, NARROW_W);
  localparam int CNT_W = $clog2(WIDE_W / NARROW_W + 1);
  localparam logic [CNT_W-1:0] RATIO_C = CNT_W'(RATIO);

  if (RATIO < 2) begin : g_ratio_check
    $error("WIDE_W must be an integer multiple of NARROW_W and at least twice as wide");
  end

  pack_state_e       state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_inc;
  logic [WIDE_W-1:0] acc;
  logic [WIDE_W-1:0] acc_wr;
  logic              accept;
  logic              full_next;
  logic              tmr_en;
  logic              tmr_clr;
  logic              expired;

  // The only combinational path: while a word waits, the producer moves only when the consumer does.
  assign in_ready  = rst_n & ((state == PK_FILL) | out_ready);
  assign accept    = in_valid & in_ready;
  assign cnt_inc   = cnt + 1'b1;
  assign full_next = (cnt_inc == RATIO_C);

  always_comb begin
    acc_wr = acc;
    for (int i = 0; i < RATIO; i++) begin
      if (cnt == CNT_W'(i)) acc_wr[i*NARROW_W +: NARROW_W] = in_data;
    end
  end

  assign tmr_en  = (state == PK_FILL) & (cnt != '0) & ~accept;
  assign tmr_clr = accept | (state == PK_EMIT);

  idle_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timeout_ctr (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .en      (tmr_en),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= PK_FILL;
      cnt        <= '0;
      acc        <= '0;
      out_beats  <= '0;
      out_padded <= 1'b0;
    end else begin
      case (state)
        PK_FILL: begin
          if (accept) begin
            acc <= acc_wr;
            cnt <= cnt_inc;
            if (full_next || flush) begin
              state      <= PK_EMIT;
              out_beats  <= cnt_inc;
              out_padded <= ~full_next;
            end
          end else if ((flush && cnt != '0) || expired) begin
            state      <= PK_EMIT;
            out_beats  <= cnt;
            out_padded <= 1'b1;
          end
        end
        PK_EMIT: begin
          if (out_ready) begin
            // A beat taken during handoff seeds lane 0 of a freshly cleared word.
            state      <= PK_FILL;
            out_beats  <= '0;
            out_padded <= 1'b0;
            acc        <= accept ? WIDE_W'(in_data) : '0;
            cnt        <= accept ? CNT_W'(1) : '0;
          end
        end
        default: state <= PK_FILL;
      endcase
    end
  end

  assign out_valid = (state == PK_EMIT);
  assign out_data  = acc;
  assign busy      = (cnt != '0) | out_valid;

endmodule

// File: tb/tb_narrow_to_wide_packer.sv
// tb/tb_narrow_to_wide_packer.sv - scoreboard bench for narrow_to_wide_packer
module tb_narrow_to_wide_packer;

  localparam int NW    = 8;
  localparam int WW    = 16;
  localparam int TO    = 16;
  localparam int RATIO = WW / NW;

  typedef struct {
    logic [WW-1:0] data;
    int            beats;
    bit            padded;
  } word_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [NW-1:0] in_data = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          in_ready;
  logic          out_valid;
  logic [WW-1:0] out_data;
  logic [1:0]    out_beats;
  logic          out_padded;
  logic          busy;

  logic          v0 = 1'b0;
  logic [NW-1:0] d0 = '0;
  logic          f0 = 1'b0;
  logic          r0 = 1'b0;
  logic          in_ready0;
  logic          out_valid0;
  logic [WW-1:0] out_data0;
  logic [1:0]    out_beats0;
  logic          out_padded0;
  logic          busy0;

  always #5 clk = ~clk;

  narrow_to_wide_packer #(.NARROW_W(NW), .WIDE_W(WW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beats(out_beats), .out_padded(out_padded), .busy(busy)
  );

  narrow_to_wide_packer #(.NARROW_W(NW), .WIDE_W(WW), .TIMEOUT(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_ready(in_ready0), .in_data(d0),
    .flush(f0), .out_valid(out_valid0), .out_ready(r0), .out_data(out_data0),
    .out_beats(out_beats0), .out_padded(out_padded0), .busy(busy0)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: beats pending in the current word, one outstanding word, idle cycle count.
  logic [NW-1:0] m_beats[$];
  bit            m_pending = 1'b0;
  int            m_idle = 0;
  bit            m_acc = 1'b0;
  word_t         exp_q[$];
  word_t         recv_q[$];

  function automatic word_t make_word();
    word_t w;
    w.data = '0;
    foreach (m_beats[k]) w.data = w.data | (WW'(m_beats[k]) << (NW * k));
    w.beats  = m_beats.size();
    w.padded = (m_beats.size() < RATIO);
    return w;
  endfunction

  task automatic model_emit();
    exp_q.push_back(make_word());
    m_pending = 1'b1;
    m_beats.delete();
    m_idle = 0;
  endtask

  always @(posedge clk) begin : model
    bit rdy;
    rdy   = rst_n && (!m_pending || out_ready);
    m_acc = in_valid && rdy;
    if (!rst_n) begin
      if (m_pending) void'(exp_q.pop_back());
      m_pending = 1'b0;
      m_beats.delete();
      m_idle = 0;
    end else if (m_pending) begin
      if (out_ready) begin
        m_pending = 1'b0;
        m_beats.delete();
        m_idle = 0;
        if (m_acc) m_beats.push_back(in_data);
      end
    end else if (m_acc) begin
      m_beats.push_back(in_data);
      m_idle = 0;
      if (m_beats.size() == RATIO || flush) model_emit();
    end else if (m_beats.size() > 0) begin
      m_idle++;
      if (flush || (TO > 0 && m_idle == TO)) model_emit();
    end
  end

  always @(negedge clk) begin : monitor
    chk("out_valid", out_valid, m_pending);
    chk("in_ready", in_ready, rst_n && (!m_pending || out_ready));
    chk("busy", busy, m_pending || (m_beats.size() != 0));
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_word", out_data, 32'hDEAD_BEEF);
      end else begin
        chk("word_data", out_data, exp_q[0].data);
        chk("word_beats", out_beats, exp_q[0].beats);
        chk("word_padded", out_padded, exp_q[0].padded);
        if (out_ready && rst_n) begin
          word_t w;
          void'(exp_q.pop_front());
          w.data = out_data;
          w.beats = out_beats;
          w.padded = out_padded;
          recv_q.push_back(w);
        end
      end
    end
  end

  task automatic step(input bit v, input logic [NW-1:0] d, input bit f, input bit r);
    in_valid = v;
    in_data = d;
    flush = f;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input string name, input logic [WW-1:0] d, input int b, input bit p);
    int k = 0;
    while (recv_q.size() == 0 && k < 50) begin
      step(1'b0, '0, 1'b0, 1'b1);
      k++;
    end
    if (recv_q.size() == 0) begin
      chk({name, "_timeout"}, 32'd0, 32'd1);
    end else begin
      word_t w;
      w = recv_q.pop_front();
      chk({name, "_data"}, w.data, d);
      chk({name, "_beats"}, w.beats, b);
      chk({name, "_padded"}, w.padded, p);
    end
  endtask

  initial begin
    int k;
    int vcount;
    int lowc;
    int idle_left;
    bit seen;
    logic [NW-1:0] src[$];

    rst_n = 1'b0;
    repeat (3) step(1'b0, '0, 1'b0, 1'b0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_data", out_data, 0);
    chk("reset_out_beats", out_beats, 0);
    chk("reset_out_padded", out_padded, 0);
    chk("reset_busy", busy, 0);
    chk("reset_in_ready", in_ready, 0);
    rst_n = 1'b1;
    step(1'b0, '0, 1'b0, 1'b1);

    // Two full beats, word one cycle after the second accept.
    step(1'b1, 8'h34, 1'b0, 1'b1);
    step(1'b1, 8'h12, 1'b0, 1'b1);
    chk("full_latency", out_valid, 1);
    step(1'b0, '0, 1'b0, 1'b1);
    expect_word("full", 16'h1234, 2, 1'b0);

    // Flush of a partial word, then flushes with nothing held.
    step(1'b1, 8'hAB, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    chk("flush_latency", out_valid, 1);
    step(1'b0, '0, 1'b0, 1'b1);
    expect_word("flush", 16'h00AB, 1, 1'b1);
    repeat (3) step(1'b0, '0, 1'b1, 1'b1);
    chk("empty_flush", out_valid, 0);
    chk("empty_flush_recv", recv_q.size(), 0);

    // Idle timeout: word appears TO clock edges after the accepting edge.
    step(1'b1, 8'h5A, 1'b0, 1'b1);
    k = 0;
    while (!out_valid && k < 40) begin
      step(1'b0, '0, 1'b0, 1'b1);
      k++;
    end
    chk("timeout_edges", k, TO);
    step(1'b0, '0, 1'b0, 1'b1);
    expect_word("timeout", 16'h005A, 1, 1'b1);

    // Backpressure for 5 cycles after the first word of a 6-beat stream.
    src = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    lowc = 0;
    seen = 1'b0;
    k = 0;
    while ((src.size() > 0 || out_valid) && k < 60) begin
      bit r;
      r = !(seen && lowc < 5);
      step(src.size() > 0, (src.size() > 0) ? src[0] : 8'h00, 1'b0, r);
      if (m_acc) void'(src.pop_front());
      if (!r) begin
        lowc++;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_hold", out_data, 16'h0201);
      end
      if (out_valid) seen = 1'b1;
      k++;
    end
    chk("bp_stalls", lowc, 5);
    expect_word("bp_w0", 16'h0201, 2, 1'b0);
    expect_word("bp_w1", 16'h0403, 2, 1'b0);
    expect_word("bp_w2", 16'h0605, 2, 1'b0);

    // Flush together with a beat at cnt==0, then a beat taken during the handoff.
    step(1'b1, 8'h77, 1'b1, 1'b1);
    step(1'b1, 8'h88, 1'b0, 1'b1);
    step(1'b1, 8'h99, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    expect_word("coflush", 16'h0077, 1, 1'b1);
    expect_word("handoff", 16'h9988, 2, 1'b0);

    // Reset while a word is held discards it; no stale upper byte afterwards.
    step(1'b1, 8'h34, 1'b0, 1'b0);
    step(1'b1, 8'h12, 1'b0, 1'b0);
    chk("pre_reset_hold", out_data, 16'h1234);
    rst_n = 1'b0;
    step(1'b0, '0, 1'b0, 1'b0);
    chk("mid_reset_valid", out_valid, 0);
    chk("mid_reset_data", out_data, 0);
    chk("mid_reset_beats", out_beats, 0);
    chk("mid_reset_busy", busy, 0);
    rst_n = 1'b1;
    step(1'b1, 8'h99, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 1'b1);
    step(1'b0, '0, 1'b0, 1'b1);
    expect_word("post_reset", 16'h0099, 1, 1'b1);

    // Randomized traffic against the model.
    idle_left = 0;
    for (int c = 0; c < 3000; c++) begin
      bit v;
      if (idle_left > 0) begin
        v = 1'b0;
        idle_left--;
      end else begin
        v = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 63) == 0) idle_left = $urandom_range(10, 25);
      end
      rst_n = ($urandom_range(0, 599) != 0);
      step(v, NW'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
    end
    rst_n = 1'b1;
    repeat (30) step(1'b0, '0, 1'b0, 1'b1);
    chk("drain_scoreboard", exp_q.size(), 0);
    recv_q.delete();

    // Timeout disabled: a lone beat stays held until flushed.
    v0 = 1'b1;
    d0 = 8'h5A;
    r0 = 1'b1;
    step(1'b0, '0, 1'b0, 1'b1);
    v0 = 1'b0;
    vcount = 0;
    for (int c = 0; c < 100; c++) begin
      step(1'b0, '0, 1'b0, 1'b1);
      if (out_valid0) vcount++;
    end
    chk("t0_no_timeout", vcount, 0);
    chk("t0_busy", busy0, 1);
    f0 = 1'b1;
    step(1'b0, '0, 1'b0, 1'b1);
    f0 = 1'b0;
    chk("t0_flush_valid", out_valid0, 1);
    chk("t0_flush_data", out_data0, 16'h005A);
    chk("t0_flush_beats", out_beats0, 1);
    chk("t0_flush_padded", out_padded0, 1);
    step(1'b0, '0, 1'b0, 1'b1);
    chk("t0_after_handoff", out_valid0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
